// File: rtl/sincpde_acc.sv
// ---------------------------------------------------------------------------
// sincpde_acc -- frame accumulator feeding the SINCPDE divider.
//
// Takes a stream of signed 18-bit sample/weight pairs. Over each frame it
// forms N = sum(X*W) and D = sum(W), both as 48-bit two's complement values
// that wrap silently. The finished pair is handed to the divider with a
// one-cycle SYNC_OUT strobe.
//
// Strobes are spaced at least DIV_GAP cycles apart, so the divider always
// finishes one quotient before the next operand pair arrives. One finished
// frame can wait in a pending buffer. The input stream is back-pressured
// while that buffer is occupied.
//
// Ports:
//   clk        clock, all state on the rising edge
//   rst        asynchronous, active-high reset
//   IN_VALID   input sample present
//   IN_READY   sample accepted on an edge where IN_VALID && IN_READY
//   IN_X       signed 18-bit sample
//   IN_W       signed 18-bit weight
//   IN_LAST    accepted sample closes the frame
//   N          signed 48-bit sum(X*W) of the issued frame, held until next issue
//   D          signed 48-bit sum(W) of the issued frame, held until next issue
//   SYNC_OUT   one-cycle strobe, N/D valid this cycle
//   ZERO_FLAG  issued frame had D == 0 (zero guard build only), held
//
// Build option:
//   SINCPDE_ACC_ZEROGUARD_EN
//     When defined, a frame whose D sum is exactly 0 is issued as N=0, D=1,
//     with ZERO_FLAG=1.
//     When undefined, sums are issued unchanged and ZERO_FLAG is tied to 0.
// ---------------------------------------------------------------------------
module sincpde_acc #(
  parameter int DIV_GAP = 80
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               IN_VALID,
  output logic               IN_READY,
  input  logic signed [17:0] IN_X,
  input  logic signed [17:0] IN_W,
  input  logic               IN_LAST,
  output logic signed [47:0] N,
  output logic signed [47:0] D,
  output logic               SYNC_OUT,
  output logic               ZERO_FLAG
);

  // The gap counter only ever holds values 0 .. DIV_GAP-1.
  localparam int GW = $clog2(DIV_GAP);
  localparam logic [GW-1:0] GAP_RELOAD = GW'(DIV_GAP - 1);

  // Stage 1: product and weight of the accepted sample.
  logic signed [35:0] s1_p_q;
  logic signed [17:0] s1_w_q;
  logic               s1_valid_q;
  logic               s1_last_q;

  // Stage 2: running sums of the open frame.
  logic signed [47:0] accn_q;
  logic signed [47:0] accd_q;

  // Pending buffer: one finished frame waiting for issue.
  logic signed [47:0] pend_n_q;
  logic signed [47:0] pend_d_q;
  logic               pend_valid_q;

  // Issue side.
  logic [GW-1:0]      gap_q;
  logic signed [47:0] n_q;
  logic signed [47:0] d_q;
  logic               sync_q;

  logic               accept;
  logic               issue;
  logic signed [35:0] x_ext;
  logic signed [35:0] w_ext;
  logic signed [35:0] prod_d;
  logic signed [47:0] accn_d;
  logic signed [47:0] accd_d;
  logic signed [47:0] iss_n_d;
  logic signed [47:0] iss_d_d;

  // Accepting a frame end blocks the next sample until it reaches the
  // pending buffer. The buffer then blocks until the frame has been issued.
  // This keeps at most one frame end in flight.
  assign IN_READY = !pend_valid_q && !s1_last_q;
  assign accept   = IN_VALID && IN_READY;
  assign issue    = pend_valid_q && (gap_q == '0);

  // Both operands are sign-extended to 36 bits before multiplying.
  // The full signed product, up to 2^34 in magnitude, fits without loss.
  assign x_ext  = 36'(IN_X);
  assign w_ext  = 36'(IN_W);
  assign prod_d = x_ext * w_ext;

  assign accn_d = accn_q + 48'(s1_p_q);
  assign accd_d = accd_q + 48'(s1_w_q);

`ifdef SINCPDE_ACC_ZEROGUARD_EN
  logic iss_zero_d;
  logic zero_q;

  // A zero denominator is replaced by 0/1, so the divider never sees D == 0.
  always_comb begin
    iss_n_d    = pend_n_q;
    iss_d_d    = pend_d_q;
    iss_zero_d = 1'b0;
    if (pend_d_q == '0) begin
      iss_n_d    = '0;
      iss_d_d    = 48'sd1;
      iss_zero_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      zero_q <= 1'b0;
    end else if (issue) begin
      zero_q <= iss_zero_d;
    end
  end

  assign ZERO_FLAG = zero_q;
`else
  assign iss_n_d   = pend_n_q;
  assign iss_d_d   = pend_d_q;
  assign ZERO_FLAG = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_p_q       <= '0;
      s1_w_q       <= '0;
      s1_valid_q   <= 1'b0;
      s1_last_q    <= 1'b0;
      accn_q       <= '0;
      accd_q       <= '0;
      pend_n_q     <= '0;
      pend_d_q     <= '0;
      pend_valid_q <= 1'b0;
      gap_q        <= '0;
      n_q          <= '0;
      d_q          <= '0;
      sync_q       <= 1'b0;
    end else begin
      // Stage 1
      s1_valid_q <= accept;
      s1_last_q  <= accept && IN_LAST;
      if (accept) begin
        s1_p_q <= prod_d;
        s1_w_q <= IN_W;
      end

      // Issue and gap counting. Issue can only clear pend_valid while
      // stage 1 holds no frame end, so the set below never collides
      // with this clear.
      if (issue) begin
        n_q          <= iss_n_d;
        d_q          <= iss_d_d;
        sync_q       <= 1'b1;
        pend_valid_q <= 1'b0;
        gap_q        <= GAP_RELOAD;
      end else begin
        sync_q <= 1'b0;
        if (gap_q != '0) begin
          gap_q <= gap_q - 1'b1;
        end
      end

      // Stage 2: accumulate, or close the frame into the pending buffer.
      if (s1_valid_q) begin
        if (s1_last_q) begin
          pend_n_q     <= accn_d;
          pend_d_q     <= accd_d;
          pend_valid_q <= 1'b1;
          accn_q       <= '0;
          accd_q       <= '0;
        end else begin
          accn_q <= accn_d;
          accd_q <= accd_d;
        end
      end
    end
  end

  assign N        = n_q;
  assign D        = d_q;
  assign SYNC_OUT = sync_q;

endmodule
